fp_seq_alu: RTL and testbench
=============================

FP_SEQ_ALU -- requirements
Module: fp_seq_alu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, total two's-complement fixed-point word width.
REQ-002 SHALL have parameter Q, default 16, fractional bit count (format Q(WIDTH-Q).Q); 1 <= Q < WIDTH.
REQ-003 SHALL have parameter SATURATE, default 1; 1 = clamp on overflow, 0 = wrap to low WIDTH bits.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clock  input  1  rising-edge clock for all state.
REQ-006 reset  input  1  synchronous active-high reset.
REQ-007 in_valid  input  1  operand/opcode presented.
REQ-008 in_ready  output  1  block can accept an operation.
REQ-009 op  input  2  00 ADD, 01 SUB, 10 MUL, 11 DIV.
REQ-010 a, b  input  WIDTH each  signed fixed-point operands.
REQ-011 out_valid  output  1  result and flags valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  WIDTH  signed fixed-point result.
REQ-014 overflow  output  1  result did not fit the format.
REQ-015 div_by_zero  output  1  DIV with b == 0.

Function
REQ-016 States: IDLE, DIV, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 Accept occurs on an edge with in_valid && in_ready; op, a, b are registered then and later input changes are ignored.
REQ-018 ADD, SUB, MUL: IDLE -> DONE on accept; out_valid rises on the edge following the accept edge (latency 1).
REQ-019 DIV: IDLE -> DIV on accept; restoring divide of unsigned (|a| << Q) by |b|, one quotient bit per cycle, WIDTH+Q iterations; DIV -> DONE after the last; out_valid at accept + WIDTH+Q+1 edges.
REQ-020 DIV with b == 0: IDLE -> DONE directly (latency 1); no iteration.
REQ-021 DONE holds result and flags stable until out_valid && out_ready; then -> IDLE; in_ready is not asserted in the same cycle as the DONE handshake.
REQ-022 ADD/SUB: computed at WIDTH+1 bits; overflow when bits WIDTH and WIDTH-1 differ.
REQ-023 MUL: 2*WIDTH-bit product of magnitudes; shifted right by Q; sign applied after shifting, so truncation is toward zero; overflow when the shifted magnitude exceeds the WIDTH-bit signed range.
REQ-024 DIV: quotient magnitude is truncated toward zero; sign = a[MSB] ^ b[MSB]; overflow when the magnitude exceeds the WIDTH-bit signed range.
REQ-025 Overflow, SATURATE=1: result = 2^(WIDTH-1)-1 for a positive true result, -2^(WIDTH-1) for a negative one.
REQ-026 Overflow, SATURATE=0: result = low WIDTH bits of the two's-complement true result.
REQ-027 Only the single most-negative value may be produced unsaturated; negative magnitude 2^(WIDTH-1) is not overflow.
REQ-028 Divide by zero: div_by_zero = 1, overflow = 0.
REQ-029 Divide by zero, result: a >= 0 gives 2^(WIDTH-1)-1; a < 0 gives -2^(WIDTH-1); independent of SATURATE.
REQ-030 Flags are 0 whenever out_valid = 0.

Reset
REQ-031 reset = 1 at any edge SHALL force IDLE and zero result, overflow, div_by_zero, out_valid, and the divider iteration counter and remainder.
REQ-032 Reset SHALL abort an in-flight DIV or held DONE result with no output; in_ready = 1 on the first edge after reset deasserts.
REQ-033 in_valid during reset SHALL be ignored.

Verification (WIDTH=32, Q=16 unless noted)
REQ-034 ADD 0x00018000 + 0x00024000 -> result 0x0003C000 one edge after accept, flags 0.
REQ-035 MUL 0xFFFE8000 x 0x00020000 -> result 0xFFFD0000 (-3.0), latency 1.
REQ-036 DIV 0x00010000 / 0x00030000 -> result 0x00005555, out_valid exactly 49 edges after accept.
REQ-037 DIV 0xFFFF0000 / 0 -> result 0x80000000, div_by_zero 1, latency 1.
REQ-038 ADD 0x7FFF0000 + 0x00020000 -> SATURATE=1: 0x7FFFFFFF, overflow 1; SATURATE=0: 0x80010000, overflow 1.
REQ-039 Hold out_ready low 5 cycles in DONE -> result stable and in_ready 0 throughout.
REQ-040 Assert reset at iteration 10 of a DIV -> out_valid 0; in_ready 1 on the first edge after reset deasserts.

Source files
------------

// File: rtl/fp_seq_alu.sv
// fp_seq_alu: sequential signed fixed-point ALU, format Q(WIDTH-Q).Q.
//   ADD/SUB/MUL finish one edge after accept; DIV runs a restoring divider
//   producing one quotient bit per cycle (WIDTH+Q iterations).
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   in_valid / in_ready   operation handshake (in_ready only while idle)
//   op                    00 ADD, 01 SUB, 10 MUL, 11 DIV
//   a, b                  signed fixed-point operands
//   out_valid / out_ready result handshake (out_valid only while done)
//   result                signed fixed-point result, held until taken
//   overflow              result did not fit the format
//   div_by_zero           DIV with b == 0
module fp_seq_alu #(
   parameter int WIDTH    = 32,
   parameter int Q        = 16,
   parameter bit SATURATE = 1'b1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             overflow,
   output logic             div_by_zero
);

   localparam int DW = WIDTH + Q;        // dividend / quotient width
   localparam int MW = 2 * WIDTH;        // magnitude width for MUL/DIV packing
   localparam int CW = $clog2(DW + 1);

   localparam logic [WIDTH-1:0] C_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] C_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] C_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [MW-1:0]    C_ONE_M = {{(MW-1){1'b0}}, 1'b1};
   localparam logic [MW-1:0]    C_LIM   = {{(WIDTH+1){1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CW-1:0]    C_LAST  = CW'(DW - 1);
   localparam logic [CW-1:0]    C_CINC  = CW'(1);

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

   state_t r_state, w_next;

   logic [WIDTH-1:0] r_result;
   logic             r_ovf;
   logic             r_dbz;
   logic             r_neg;
   logic [WIDTH-1:0] r_bmag;
   logic [WIDTH-1:0] r_rem;
   logic [DW-1:0]    r_quo;
   logic [CW-1:0]    r_cnt;

   // Turn a magnitude plus sign into {overflow, result}. A negative
   // magnitude of exactly 2^(WIDTH-1) is representable.
   function automatic logic [WIDTH:0] f_pack(input logic [MW-1:0] mag, input logic neg);
      logic [MW-1:0]    tc;
      logic             ovf;
      logic [WIDTH-1:0] res;
      ovf = neg ? (mag > C_LIM) : (mag >= C_LIM);
      tc  = neg ? (~mag + C_ONE_M) : mag;
      if (ovf && SATURATE) res = neg ? C_MIN : C_MAX;
      else                 res = tc[WIDTH-1:0];
      return {ovf, res};
   endfunction

   // ADD / SUB at WIDTH+1 bits
   logic [WIDTH:0]   w_a_ext, w_b_ext, w_sum;
   logic             w_as_ovf;
   logic [WIDTH-1:0] w_as_res;

   always_comb begin
      w_a_ext  = {a[WIDTH-1], a};
      w_b_ext  = {b[WIDTH-1], b};
      w_sum    = op[0] ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
      w_as_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
      if (w_as_ovf && SATURATE) w_as_res = w_sum[WIDTH] ? C_MIN : C_MAX;
      else                      w_as_res = w_sum[WIDTH-1:0];
   end

   // MUL on magnitudes; sign applied after the Q shift truncates toward zero
   logic [WIDTH-1:0] w_amag, w_bmag;
   logic [MW-1:0]    w_prod, w_mul_mag;
   logic [WIDTH:0]   w_mul_pk;

   always_comb begin
      w_amag    = a[WIDTH-1] ? (~a + C_ONE) : a;
      w_bmag    = b[WIDTH-1] ? (~b + C_ONE) : b;
      w_prod    = {{WIDTH{1'b0}}, w_amag} * {{WIDTH{1'b0}}, w_bmag};
      w_mul_mag = w_prod >> Q;
      w_mul_pk  = f_pack(w_mul_mag, a[WIDTH-1] ^ b[WIDTH-1]);
   end

   // Restoring divider step: r_quo starts as the dividend and shifts left,
   // feeding its MSB into the remainder while quotient bits enter at the LSB.
   logic [WIDTH:0]   w_shift, w_diff;
   logic             w_ge;
   logic [WIDTH-1:0] w_rem_nx;
   logic [DW-1:0]    w_quo_nx;
   logic [WIDTH:0]   w_div_pk;
   logic             w_div_last;

   always_comb begin
      w_shift    = {r_rem, r_quo[DW-1]};
      w_ge       = (w_shift >= {1'b0, r_bmag});
      w_diff     = w_shift - {1'b0, r_bmag};
      w_rem_nx   = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
      w_quo_nx   = {r_quo[DW-2:0], w_ge};
      w_div_pk   = f_pack({{(MW-DW){1'b0}}, w_quo_nx}, r_neg);
      w_div_last = (r_cnt == C_LAST);
   end

   // FSM
   always_ff @(posedge clock) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next    = r_state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (r_state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               if (op == 2'b11 && b != '0) w_next = S_DIV;
               else                        w_next = S_DONE;
            end
         end
         S_DIV: begin
            if (w_div_last) w_next = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath
   always_ff @(posedge clock) begin
      if (reset) begin
         r_result <= '0;
         r_ovf    <= 1'b0;
         r_dbz    <= 1'b0;
         r_neg    <= 1'b0;
         r_bmag   <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  case (op)
                     2'b00, 2'b01: begin
                        r_result <= w_as_res;
                        r_ovf    <= w_as_ovf;
                        r_dbz    <= 1'b0;
                     end
                     2'b10: begin
                        {r_ovf, r_result} <= w_mul_pk;
                        r_dbz             <= 1'b0;
                     end
                     default: begin
                        if (b == '0) begin
                           r_result <= a[WIDTH-1] ? C_MIN : C_MAX;
                           r_ovf    <= 1'b0;
                           r_dbz    <= 1'b1;
                        end else begin
                           r_neg  <= a[WIDTH-1] ^ b[WIDTH-1];
                           r_bmag <= w_bmag;
                           r_quo  <= {w_amag, {Q{1'b0}}};
                           r_rem  <= '0;
                           r_cnt  <= '0;
                           r_ovf  <= 1'b0;
                           r_dbz  <= 1'b0;
                        end
                     end
                  endcase
               end
            end
            S_DIV: begin
               r_rem <= w_rem_nx;
               r_quo <= w_quo_nx;
               if (w_div_last) begin
                  {r_ovf, r_result} <= w_div_pk;
                  r_cnt             <= '0;
               end else begin
                  r_cnt <= r_cnt + C_CINC;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_ovf <= 1'b0;
                  r_dbz <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign result      = r_result;
   assign overflow    = r_ovf & out_valid;
   assign div_by_zero = r_dbz & out_valid;

endmodule

// File: tb/tb_fp_seq_alu.sv
// Bench for fp_seq_alu: two instances (saturating and wrapping) share one
// stimulus stream; results are compared against a 64-bit arithmetic model.
module tb_fp_seq_alu;

   localparam int W = 32;
   localparam int QB = 16;

   logic          clock, reset, in_valid, out_ready;
   logic [1:0]    op;
   logic [W-1:0]  a, b;

   logic          s_in_ready, s_out_valid, s_overflow, s_dbz;
   logic [W-1:0]  s_result;
   logic          w_in_ready, w_out_valid, w_overflow, w_dbz;
   logic [W-1:0]  w_result;

   int checks   = 0;
   int failures = 0;

   fp_seq_alu #(.WIDTH(W), .Q(QB), .SATURATE(1'b1)) dut_s (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
      .op(op), .a(a), .b(b), .out_valid(s_out_valid), .out_ready(out_ready),
      .result(s_result), .overflow(s_overflow), .div_by_zero(s_dbz)
   );

   fp_seq_alu #(.WIDTH(W), .Q(QB), .SATURATE(1'b0)) dut_w (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready),
      .op(op), .a(a), .b(b), .out_valid(w_out_valid), .out_ready(out_ready),
      .result(w_result), .overflow(w_overflow), .div_by_zero(w_dbz)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: true result in 64-bit signed arithmetic, then format rules.
   task automatic model(input logic [1:0] mop, input logic [W-1:0] ma, input logic [W-1:0] mb,
                        input bit sat, output logic [W-1:0] res, output logic ovf,
                        output logic dbz);
      longint sa, sb, aa, ab, t, maxv, minv;
      maxv = 64'sd2147483647;
      minv = -maxv - 1;
      sa = longint'($signed(ma));
      sb = longint'($signed(mb));
      aa = (sa < 0) ? -sa : sa;
      ab = (sb < 0) ? -sb : sb;
      dbz = 1'b0;
      t = 0;
      case (mop)
         2'b00: t = sa + sb;
         2'b01: t = sa - sb;
         2'b10: begin
            t = (aa * ab) / 65536;
            if ((sa < 0) != (sb < 0)) t = -t;
         end
         default: begin
            if (sb == 0) dbz = 1'b1;
            else begin
               t = (aa * 65536) / ab;
               if ((sa < 0) != (sb < 0)) t = -t;
            end
         end
      endcase
      if (dbz) begin
         ovf = 1'b0;
         res = (sa >= 0) ? 32'h7FFFFFFF : 32'h80000000;
      end else begin
         ovf = (t > maxv) || (t < minv);
         if (ovf && sat) res = (t < 0) ? 32'h80000000 : 32'h7FFFFFFF;
         else            res = t[31:0];
      end
   endtask

   // Entry and exit at a negedge.
   task automatic do_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        input int hold);
      logic [W-1:0] er_s, er_w;
      logic         eo_s, eo_w, ed_s, ed_w;
      int           lat, exp_lat;
      model(o, x, y, 1'b1, er_s, eo_s, ed_s);
      model(o, x, y, 1'b0, er_w, eo_w, ed_w);
      exp_lat = (o == 2'b11 && y != 0) ? (W + QB + 1) : 1;
      in_valid = 1'b1; op = o; a = x; b = y;
      chk("in_ready_s", 64'(s_in_ready), 64'd1);
      chk("in_ready_w", 64'(w_in_ready), 64'd1);
      @(posedge clock); #1;
      in_valid = 1'b0; op = 2'($urandom); a = $urandom; b = $urandom;
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (s_out_valid !== 1'b1 && lat < 100);
      chk("latency", 64'(lat), 64'(exp_lat));
      chk("out_valid_w", 64'(w_out_valid), 64'd1);
      chk("result_s", 64'(s_result), 64'(er_s));
      chk("result_w", 64'(w_result), 64'(er_w));
      chk("overflow_s", 64'(s_overflow), 64'(eo_s));
      chk("overflow_w", 64'(w_overflow), 64'(eo_w));
      chk("dbz_s", 64'(s_dbz), 64'(ed_s));
      chk("dbz_w", 64'(w_dbz), 64'(ed_w));
      repeat (hold) begin
         @(negedge clock);
         chk("hold_result", 64'(s_result), 64'(er_s));
         chk("hold_valid", 64'(s_out_valid), 64'd1);
         chk("hold_in_ready", 64'(s_in_ready), 64'd0);
      end
      out_ready = 1'b1;
      chk("handshake_in_ready", 64'({s_in_ready, w_in_ready}), 64'd0);
      @(posedge clock); #1;
      out_ready = 1'b0;
      @(negedge clock);
      chk("release_valid", 64'({s_out_valid, w_out_valid}), 64'd0);
      chk("release_in_ready", 64'({s_in_ready, w_in_ready}), 64'd3);
      chk("release_flags", 64'({s_overflow, s_dbz, w_overflow, w_dbz}), 64'd0);
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0: return $urandom;
         1: return W'($signed($urandom_range(0, 32'h00FFFFFF)) - 32'sh00800000);
         2: return 32'h80000000;
         3: return 32'h7FFFFFFF;
         4: return W'($signed($urandom_range(0, 32'h0003FFFF)) - 32'sh00020000);
         default: return '0;
      endcase
   endfunction

   initial begin
      reset = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
      op = 2'b00; a = 32'h00010000; b = 32'h00010000;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_out_valid", 64'({s_out_valid, w_out_valid}), 64'd0);
      chk("rst_result", 64'({s_result, w_result}), 64'd0);
      chk("rst_flags", 64'({s_overflow, s_dbz, w_overflow, w_dbz}), 64'd0);
      reset = 1'b0; in_valid = 1'b0;
      @(negedge clock);
      chk("post_rst_in_ready", 64'(s_in_ready), 64'd1);
      chk("post_rst_out_valid", 64'(s_out_valid), 64'd0);

      do_op(2'b00, 32'h00018000, 32'h00024000, 0);
      do_op(2'b10, 32'hFFFE8000, 32'h00020000, 0);
      do_op(2'b11, 32'h00010000, 32'h00030000, 0);
      do_op(2'b11, 32'hFFFF0000, 32'h00000000, 0);
      do_op(2'b00, 32'h7FFF0000, 32'h00020000, 0);
      do_op(2'b01, 32'h80000000, 32'h00010000, 0);
      do_op(2'b01, 32'h00000000, 32'h80000000, 0);
      do_op(2'b11, 32'h80000000, 32'h80000000, 0);
      do_op(2'b11, 32'h7FFFFFFF, 32'h00000001, 0);
      do_op(2'b10, 32'h80000000, 32'h00010000, 0);
      do_op(2'b00, 32'h00050000, 32'hFFFF0000, 5);

      // Reset in the middle of a divide
      in_valid = 1'b1; op = 2'b11; a = 32'h00050000; b = 32'h00030000;
      @(posedge clock); #1;
      in_valid = 1'b0;
      repeat (9) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("abort_out_valid", 64'(s_out_valid), 64'd0);
      reset = 1'b0;
      @(negedge clock);
      chk("abort_in_ready", 64'(s_in_ready), 64'd1);
      chk("abort_result", 64'(s_result), 64'd0);
      repeat (60) @(negedge clock);
      chk("abort_no_output", 64'({s_out_valid, w_out_valid}), 64'd0);

      for (int i = 0; i < 60; i++) begin
         logic [1:0]   ro;
         logic [W-1:0] ra, rb;
         ro = 2'($urandom_range(0, 3));
         ra = pick();
         rb = pick();
         do_op(ro, ra, rb, int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
